// File: rtl/wbr_msg_sched_pkg.sv
// Shared constants for the wideband-receiver message scheduler: WSI command codes,
// register map, CTRL bit positions and FSM state encoding.
package wbr_msg_sched_pkg;

  localparam logic [2:0] WSI_IDLE = 3'b000;
  localparam logic [2:0] WSI_WR   = 3'b001;

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_MSG_WORDS = 3'd1;
  localparam logic [2:0] ADDR_MSG_COUNT = 3'd2;
  localparam logic [2:0] ADDR_STATUS    = 3'd3;
  localparam logic [2:0] ADDR_DROPS     = 3'd4;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CONT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3
  } sched_state_e;

endpackage

// File: rtl/wbr_msg_sched_sample_packer.sv
// Pairs 16-bit samples into 32-bit words and holds the word until the chan side takes it.
// During flush it completes a pending half-word with zeros and emits zero pad words.
module wbr_msg_sched_sample_packer
  import wbr_msg_sched_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_pack,
  input  logic [15:0] i_sample,
  input  logic        i_flush,
  input  logic        i_pad_pending,
  input  logic        i_last,
  input  logic        i_chan_busy,
  output logic        o_load,
  output logic        o_xfer,
  output logic        o_out_valid,
  output logic        o_out_last,
  output logic [31:0] o_out_data,
  output logic        o_half_valid
);

  logic        r_half_valid;
  logic [15:0] r_half;
  logic        r_out_valid;
  logic        r_out_last;
  logic [31:0] r_out_data;

  logic        w_out_free;
  logic        w_xfer;
  logic        w_load_pair;
  logic        w_load_pad;
  logic        w_load;
  logic [31:0] w_load_data;

  // The output register may reload in the same cycle it drains.
  assign w_out_free  = !r_out_valid || !i_chan_busy;
  assign w_xfer      = r_out_valid && !i_chan_busy;
  assign w_load_pair = i_pack && r_half_valid;
  assign w_load_pad  = i_flush && w_out_free && (r_half_valid || i_pad_pending);
  assign w_load      = w_load_pair || w_load_pad;
  assign w_load_data = w_load_pair  ? {i_sample, r_half} :
                       r_half_valid ? {16'h0000, r_half} : 32'h0000_0000;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_half_valid <= 1'b0;
      r_half       <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_data   <= '0;
    end else if (i_clr) begin
      r_half_valid <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      if (w_load) begin
        r_half_valid <= 1'b0;
      end else if (i_pack) begin
        r_half       <= i_sample;
        r_half_valid <= 1'b1;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_load_data;
        r_out_last  <= i_last;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_load       = w_load;
  assign o_xfer       = w_xfer;
  assign o_out_valid  = r_out_valid;
  assign o_out_last   = r_out_last;
  assign o_out_data   = r_out_data;
  assign o_half_valid = r_half_valid;

endmodule

// File: rtl/wbr_msg_sched.sv
// Message scheduler: frames packed sample words into fixed-length bursts for the chan port.
// Optional drop statistics are built when WBR_SCHED_STATS_EN is defined.
//
// state | meaning
// IDLE  | not scheduling; incoming samples are drained
// RUN   | packing samples and emitting message words
// FLUSH | aborting: pad current message with zeros, then IDLE
// DONE  | configured message count sent; samples drained
module wbr_msg_sched
  import wbr_msg_sched_pkg::*;
#(
  parameter int MAXLEN_W = 12,
  parameter int CNT_W    = 16
) (
  input  logic                ctl_Clk,
  input  logic                ctl_MReset,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [31:0]         cfg_wdata,
  output logic [31:0]         cfg_rdata,
  input  logic [2:0]          dif_MCmd,
  input  logic [15:0]         dif_MData,
  output logic                dif_SThreadBusy,
  output logic [2:0]          chan_MCmd,
  output logic                chan_MReqLast,
  output logic [MAXLEN_W-1:0] chan_MBurstLength,
  output logic [31:0]         chan_MData,
  input  logic                chan_SThreadBusy,
  output logic                sched_active,
  output logic                sched_done
);

  sched_state_e        r_state;
  sched_state_e        w_state_next;

  logic [MAXLEN_W-1:0] r_msg_words;
  logic [CNT_W-1:0]    r_msg_count;
  logic [MAXLEN_W-1:0] r_len;
  logic [CNT_W-1:0]    r_count;
  logic                r_cont;
  logic [CNT_W-1:0]    r_msgs_sent;
  logic                r_cfg_err;
  logic [MAXLEN_W-1:0] r_word_cnt;
  logic                r_final_loaded;

  logic                w_ctrl_wr;
  logic                w_start;
  logic                w_abort;
  logic                w_idle_like;
  logic                w_start_ok;
  logic                w_start_err;
  logic                w_run;
  logic                w_flush;
  logic                w_dif_busy;
  logic                w_accept;
  logic                w_pack;
  logic                w_last;
  logic                w_load;
  logic                w_xfer;
  logic                w_out_valid;
  logic                w_out_last;
  logic [31:0]         w_out_data;
  logic                w_half_valid;
  logic                w_last_xfer;
  logic [CNT_W-1:0]    w_eff_count;
  logic [CNT_W-1:0]    w_sent_next;
  logic                w_done_hit;
  logic                w_final_hit;
  logic                w_boundary;
  logic                w_flush_empty;
  logic [31:0]         w_drops;
  logic                w_unused;

  assign w_unused    = ^cfg_wdata;

  assign w_ctrl_wr   = cfg_we && (cfg_addr == ADDR_CTRL);
  assign w_abort     = w_ctrl_wr && cfg_wdata[CTRL_ABORT];
  assign w_start     = w_ctrl_wr && cfg_wdata[CTRL_START] && !cfg_wdata[CTRL_ABORT];
  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_start_ok  = w_start && w_idle_like && (r_msg_words != '0);
  assign w_start_err = w_start && w_idle_like && (r_msg_words == '0);
  assign w_run       = (r_state == ST_RUN);
  assign w_flush     = (r_state == ST_FLUSH);

  // Only registered state and the downstream busy feed back to the sample source.
  assign w_dif_busy  = (w_run && w_out_valid && w_half_valid && chan_SThreadBusy) || w_flush;
  assign w_accept    = (dif_MCmd == WSI_WR) && !w_dif_busy;
  // Once the final word of a bounded run is loaded, further samples are discarded.
  assign w_pack      = w_run && w_accept && !r_final_loaded;

  assign w_last      = (r_word_cnt == (r_len - MAXLEN_W'(1)));
  assign w_last_xfer = w_xfer && w_out_last;
  assign w_eff_count = (r_count == '0) ? CNT_W'(1) : r_count;
  assign w_sent_next = r_msgs_sent + CNT_W'(w_run && w_last_xfer);
  assign w_done_hit  = w_run && w_last_xfer && !r_cont &&
                       ((r_msgs_sent + CNT_W'(1)) == w_eff_count);
  assign w_final_hit = !r_cont && ((w_sent_next + CNT_W'(1)) == w_eff_count);

  assign w_flush_empty = (r_word_cnt == '0) && !w_half_valid && !w_out_valid;
  assign w_boundary    = w_flush_empty && !w_pack;

  wbr_msg_sched_sample_packer u_packer (
    .i_clk         (ctl_Clk),
    .i_rst         (ctl_MReset),
    .i_clr         (w_start_ok),
    .i_pack        (w_pack),
    .i_sample      (dif_MData),
    .i_flush       (w_flush),
    .i_pad_pending (r_word_cnt != '0),
    .i_last        (w_last),
    .i_chan_busy   (chan_SThreadBusy),
    .o_load        (w_load),
    .o_xfer        (w_xfer),
    .o_out_valid   (w_out_valid),
    .o_out_last    (w_out_last),
    .o_out_data    (w_out_data),
    .o_half_valid  (w_half_valid)
  );

  always_ff @(posedge ctl_Clk) begin
    if (ctl_MReset) r_state <= ST_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_start_ok) w_state_next = ST_RUN;
      ST_RUN: begin
        if (w_abort)         w_state_next = w_boundary ? ST_IDLE : ST_FLUSH;
        else if (w_done_hit) w_state_next = ST_DONE;
      end
      ST_FLUSH: if (w_flush_empty) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ctl_Clk) begin
    if (ctl_MReset) begin
      r_msg_words    <= MAXLEN_W'(1);
      r_msg_count    <= CNT_W'(1);
      r_len          <= '0;
      r_count        <= '0;
      r_cont         <= 1'b0;
      r_msgs_sent    <= '0;
      r_cfg_err      <= 1'b0;
      r_word_cnt     <= '0;
      r_final_loaded <= 1'b0;
    end else begin
      if (cfg_we && (cfg_addr == ADDR_MSG_WORDS)) r_msg_words <= cfg_wdata[MAXLEN_W-1:0];
      if (cfg_we && (cfg_addr == ADDR_MSG_COUNT)) r_msg_count <= cfg_wdata[CNT_W-1:0];
      if (w_start_err) r_cfg_err <= 1'b1;
      if (w_start_ok) begin
        r_len          <= r_msg_words;
        r_count        <= r_msg_count;
        r_cont         <= cfg_wdata[CTRL_CONT];
        r_msgs_sent    <= '0;
        r_cfg_err      <= 1'b0;
        r_word_cnt     <= '0;
        r_final_loaded <= 1'b0;
      end else begin
        r_msgs_sent <= w_sent_next;
        if (w_load) begin
          r_word_cnt <= w_last ? '0 : r_word_cnt + MAXLEN_W'(1);
          if (w_run && w_last && w_final_hit) r_final_loaded <= 1'b1;
        end
      end
    end
  end

`ifdef WBR_SCHED_STATS_EN
  logic [31:0] r_drops;

  always_ff @(posedge ctl_Clk) begin
    if (ctl_MReset)                         r_drops <= '0;
    else if (w_start && w_idle_like)        r_drops <= '0;
    else if (w_idle_like && (dif_MCmd == WSI_WR) && (r_drops != 32'hFFFF_FFFF))
                                            r_drops <= r_drops + 32'd1;
  end

  assign w_drops = r_drops;
`else
  assign w_drops = '0;
`endif

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_MSG_WORDS: cfg_rdata[MAXLEN_W-1:0] = r_msg_words;
      ADDR_MSG_COUNT: cfg_rdata[CNT_W-1:0]    = r_msg_count;
      ADDR_STATUS: begin
        cfg_rdata[2:0]        = r_state;
        cfg_rdata[3]          = r_cfg_err;
        cfg_rdata[16 +: CNT_W] = r_msgs_sent;
      end
      ADDR_DROPS:     cfg_rdata = w_drops;
      default:        cfg_rdata = '0;
    endcase
  end

  assign dif_SThreadBusy   = w_dif_busy;
  assign chan_MCmd         = w_out_valid ? WSI_WR : WSI_IDLE;
  assign chan_MReqLast     = w_out_valid && w_out_last;
  assign chan_MData        = w_out_data;
  assign chan_MBurstLength = r_len;
  assign sched_active      = w_run || w_flush;
  assign sched_done        = (r_state == ST_DONE);

endmodule
